// File: rtl/sfp_tx_pkg.sv
// Shared constants and types for the video-to-SFP transmit path.
// K-characters, the IDLE comma word and the TX FSM state encoding live here.
`timescale 1ns/1ps
package sfp_tx_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] D16_2 = 8'h50;

    localparam logic [31:0] IDLE_WORD    = {D16_2, K28_5, D16_2, K28_5};
    localparam logic [3:0]  IDLE_CHARISK = 4'b0101;
    localparam logic [3:0]  CTRL_CHARISK = 4'b0001;
    localparam logic [3:0]  DATA_CHARISK = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TAIL
    } tx_state_t;

    // Header word: K27.7 in byte 0, start-of-frame flag in bit 8, line number on top.
    function automatic logic [31:0] hdr_word(input logic [15:0] line_no, input logic sof);
        return {line_no, 7'd0, sof, K27_7};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a registered read port.
// Read data is valid the cycle after a read is accepted.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH   = 24,
    parameter int FIFO_AW = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/video_to_sfp_tx.sv
// Buffers active video lines and retransmits each as a framed 8b10b word stream:
// K27.7 header, little-endian packed pixel words, K29.7 tail with XOR checksum.
`timescale 1ns/1ps
module video_to_sfp_tx
    import sfp_tx_pkg::*;
#(
    parameter int H_DISP  = 1280,
    parameter int FIFO_AW = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vin_vsync,
    input  logic        vin_hsync,
    input  logic [23:0] vin_dat,
    input  logic        vin_valid,
    input  logic        tx_en,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_charisk,
    output logic        ovf_err,
    output logic        len_err,
    output logic [15:0] line_num
);

    localparam int WORDS  = H_DISP * 3 / 4;
    localparam int LP_MAX = (1 << FIFO_AW) / H_DISP + 1;
    localparam int LP_W   = $clog2(LP_MAX + 1);
    localparam int PIX_W  = $clog2(H_DISP + 1);
    localparam int WORD_W = $clog2(WORDS + 1);

    localparam logic [PIX_W-1:0]  PIX_ONE   = {{(PIX_W-1){1'b0}}, 1'b1};
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(H_DISP - 1);
    localparam logic [PIX_W-1:0]  PIX_TOTAL = PIX_W'(H_DISP);
    localparam logic [WORD_W-1:0] WORD_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [LP_W-1:0]   LP_ONE    = {{(LP_W-1){1'b0}}, 1'b1};
    localparam logic [LP_W-1:0]   LP_SAT    = LP_W'(LP_MAX);

    logic              hsync_unused;
    logic              vsync_q;
    logic              vsync_rise;
    logic [PIX_W-1:0]  wr_cnt;
    logic              wr_accept;
    logic              line_done;
    logic              line_sent;
    logic [LP_W-1:0]   lines_pending;
    logic              restart_req;
    logic [15:0]       next_line;
    logic [15:0]       hdr_line;

    logic              fifo_full;
    logic              fifo_empty;
    logic [23:0]       rd_data;
    logic              rd_en;
    logic              rd_valid;
    logic [PIX_W-1:0]  rd_cnt;

    tx_state_t         state;
    tx_state_t         state_d;
    logic [31:0]       tx_data_d;
    logic [3:0]        tx_charisk_d;
    logic              emit;
    logic [WORD_W-1:0] wd_cnt;
    logic [23:0]       csum;

    logic [63:0]       gb_buf;
    logic [63:0]       gb_buf_d;
    logic [3:0]        gb_cnt;
    logic [3:0]        gb_cnt_d;

    // Line framing comes from the pixel count alone; hsync is carried but ignored.
    assign hsync_unused = vin_hsync;

    assign vsync_rise = vin_vsync && !vsync_q;
    assign wr_accept  = vin_valid && !fifo_full;
    assign line_done  = wr_accept && !vsync_rise && (wr_cnt == LAST_PIX);
    assign line_sent  = (state == ST_TAIL);
    assign hdr_line   = restart_req ? 16'd0 : next_line;

    sync_fifo #(
        .WIDTH   (24),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vin_valid),
        .wr_data (vin_dat),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Dropped pixels are not counted so the FIFO content stays line-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            wr_cnt        <= '0;
            lines_pending <= '0;
            restart_req   <= 1'b0;
            ovf_err       <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            vsync_q <= vin_vsync;

            if (vsync_rise) begin
                wr_cnt <= wr_accept ? PIX_ONE : '0;
                if (wr_cnt != '0) begin
                    len_err <= 1'b1;
                end
            end else if (wr_accept) begin
                wr_cnt <= (wr_cnt == LAST_PIX) ? '0 : wr_cnt + PIX_ONE;
            end

            if (vin_valid && fifo_full) begin
                ovf_err <= 1'b1;
            end

            if (line_done && !line_sent && lines_pending != LP_SAT) begin
                lines_pending <= lines_pending + LP_ONE;
            end else if (!line_done && line_sent) begin
                lines_pending <= lines_pending - LP_ONE;
            end

            if (vsync_rise) begin
                restart_req <= 1'b1;
            end else if (state == ST_HDR) begin
                restart_req <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state;
        tx_data_d    = IDLE_WORD;
        tx_charisk_d = IDLE_CHARISK;
        rd_en        = 1'b0;
        emit         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lines_pending != '0 && tx_en) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_data_d    = hdr_word(hdr_line, restart_req);
                tx_charisk_d = CTRL_CHARISK;
                state_d      = ST_DATA;
            end
            ST_DATA: begin
                rd_en = (rd_cnt != PIX_TOTAL) && !fifo_empty;
                if (gb_cnt >= 4'd4) begin
                    emit         = 1'b1;
                    tx_data_d    = gb_buf[31:0];
                    tx_charisk_d = DATA_CHARISK;
                    if (wd_cnt == LAST_WORD) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                tx_data_d    = {csum, K29_7};
                tx_charisk_d = CTRL_CHARISK;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gearbox: at most one 3-byte pixel enters per cycle while up to 4 bytes leave,
    // so occupancy never exceeds 6 bytes and no read-side backpressure is needed.
    always_comb begin
        gb_buf_d = gb_buf;
        gb_cnt_d = gb_cnt;
        if (emit) begin
            gb_buf_d = {32'd0, gb_buf[63:32]};
            gb_cnt_d = gb_cnt - 4'd4;
        end
        if (rd_valid) begin
            gb_buf_d = gb_buf_d | ({40'd0, rd_data} << {gb_cnt_d, 3'b000});
            gb_cnt_d = gb_cnt_d + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx_data    <= IDLE_WORD;
            tx_charisk <= IDLE_CHARISK;
            rd_valid   <= 1'b0;
            rd_cnt     <= '0;
            wd_cnt     <= '0;
            csum       <= '0;
            gb_buf     <= '0;
            gb_cnt     <= '0;
            line_num   <= '0;
            next_line  <= '0;
        end else begin
            state      <= state_d;
            tx_data    <= tx_data_d;
            tx_charisk <= tx_charisk_d;
            rd_valid   <= rd_en;
            gb_buf     <= gb_buf_d;
            gb_cnt     <= gb_cnt_d;

            if (rd_en) begin
                rd_cnt <= rd_cnt + PIX_ONE;
            end
            if (emit) begin
                wd_cnt <= wd_cnt + WORD_ONE;
            end
            if (rd_valid) begin
                csum <= csum ^ rd_data;
            end

            if (state == ST_HDR) begin
                line_num <= hdr_line;
            end

            if (state == ST_TAIL) begin
                rd_cnt    <= '0;
                wd_cnt    <= '0;
                csum      <= '0;
                next_line <= line_num + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_to_sfp_tx.sv
// Self-checking bench: a line-level model predicts the framed word stream,
// and a compare process checks every non-idle output word against it.
`timescale 1ns/1ps
module tb_video_to_sfp_tx;
    import sfp_tx_pkg::*;

    localparam int H_DISP  = 8;
    localparam int FIFO_AW = 3;
    localparam int WORDS   = H_DISP * 3 / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vin_vsync = 1'b0;
    logic        vin_hsync = 1'b0;
    logic [23:0] vin_dat = '0;
    logic        vin_valid = 1'b0;
    logic        tx_en = 1'b0;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic        ovf_err;
    logic        len_err;
    logic [15:0] line_num;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    word_t       exp_q[$];
    word_t       rec_q[$];
    logic [23:0] line_buf[$];
    int          checks = 0;
    int          failures = 0;
    int          data_seen = 0;
    int          model_next_line = 0;
    bit          model_restart = 1'b0;

    always #5 clk = ~clk;

    video_to_sfp_tx #(
        .H_DISP  (H_DISP),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vin_vsync  (vin_vsync),
        .vin_hsync  (vin_hsync),
        .vin_dat    (vin_dat),
        .vin_valid  (vin_valid),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_charisk (tx_charisk),
        .ovf_err    (ovf_err),
        .len_err    (len_err),
        .line_num   (line_num)
    );

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Expected frame for one complete line: header, packed pixel bytes, XOR tail.
    task automatic modelLine();
        logic [7:0]  bytes[$];
        logic [23:0] x;
        logic [23:0] p;
        word_t       w;
        int          ln;
        x  = '0;
        ln = model_restart ? 0 : model_next_line;
        w.d = {16'(ln), 7'd0, model_restart, 8'hFB};
        w.k = 4'b0001;
        exp_q.push_back(w);
        foreach (line_buf[i]) begin
            p = line_buf[i];
            x = x ^ p;
            for (int b = 0; b < 3; b++) bytes.push_back(p[8*b +: 8]);
        end
        for (int n = 0; n < WORDS; n++) begin
            w.d = {bytes[4*n+3], bytes[4*n+2], bytes[4*n+1], bytes[4*n]};
            w.k = 4'b0000;
            exp_q.push_back(w);
        end
        w.d = {x, 8'hFD};
        w.k = 4'b0001;
        exp_q.push_back(w);
        model_next_line = ln + 1;
        model_restart   = 1'b0;
        line_buf.delete();
    endtask

    task automatic modelPixel(input logic [23:0] px);
        line_buf.push_back(px);
        if (line_buf.size() == H_DISP) modelLine();
    endtask

    always @(negedge clk) begin : compare
        word_t got;
        word_t want;
        if (rst_n && !(tx_data == IDLE_WORD && tx_charisk == IDLE_CHARISK)) begin
            got.d = tx_data;
            got.k = tx_charisk;
            rec_q.push_back(got);
            if (tx_charisk == 4'b0000) data_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_word: got data=%h charisk=%b, expected idle", got.d, got.k);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL stream_word: got data=%h charisk=%b, expected data=%h charisk=%b",
                             got.d, got.k, want.d, want.k);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseVsync();
        vin_vsync = 1'b1;
        tick();
        vin_vsync = 1'b0;
        tick();
        model_restart = 1'b1;
        line_buf.delete();
    endtask

    task automatic applyStimulus(input int n, input logic [23:0] seed, input logic [23:0] step, input bit feed_model);
        logic [23:0] p;
        p = seed;
        for (int i = 0; i < n; i++) begin
            vin_valid = 1'b1;
            vin_dat   = p;
            vin_hsync = (i == 0);
            if (feed_model) modelPixel(p);
            tick();
            p = p + step;
        end
        vin_valid = 1'b0;
        vin_hsync = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: %0d words pending after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic waitData(input string name);
        int start;
        int n;
        start = data_seen;
        n = 0;
        while (data_seen == start && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (data_seen == start) begin
            failures++;
            $display("[TB] FAIL %s_data_wait: no data word within %0d cycles, required one", name, n);
        end
    endtask

    function automatic logic [35:0] recAt(input int i);
        if (i < rec_q.size()) return {rec_q[i].k, rec_q[i].d};
        return {36{1'bx}};
    endfunction

    localparam logic [35:0] IDLE36 = {4'b0101, 32'h50BC_50BC};

    initial begin
        logic [31:0] lit_d [0:7];
        logic [3:0]  lit_k [0:7];
        lit_d = '{32'h0000_01FB, 32'h0200_0001, 32'h0003_0000, 32'h0000_0400,
                  32'h0600_0005, 32'h0007_0000, 32'h0000_0800, 32'h0000_08FD};
        lit_k = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

        repeat (3) tick();
        checkOutput("rst_tx_data", 36'(tx_data), 36'h0_50BC_50BC);
        checkOutput("rst_charisk", 36'(tx_charisk), 36'h5);
        checkOutput("rst_ovf_err", 36'(ovf_err), 36'h0);
        checkOutput("rst_len_err", 36'(len_err), 36'h0);
        checkOutput("rst_line_num", 36'(line_num), 36'h0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        tick();

        // First line after a vsync: header latency and literal word stream.
        pulseVsync();
        applyStimulus(H_DISP, 24'h000001, 24'h000001, 1'b1);
        tick();
        checkOutput("hdr_latency_idle", {tx_charisk, tx_data}, IDLE36);
        tick();
        checkOutput("hdr_latency_hdr", {tx_charisk, tx_data}, {4'b0001, 32'h0000_01FB});
        waitDrain("line0");
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("line0_word%0d", i), recAt(i), {lit_k[i], lit_d[i]});
        checkOutput("line0_line_num", 36'(line_num), 36'h0);
        rec_q.delete();

        applyStimulus(H_DISP, 24'h000001, 24'h000001, 1'b1);
        waitDrain("line1");
        checkOutput("line1_header", recAt(0), {4'b0001, 32'h0001_00FB});
        checkOutput("line1_tail", recAt(7), {4'b0001, 32'h0000_08FD});
        checkOutput("line1_line_num", 36'(line_num), 36'h1);
        rec_q.delete();

        // tx_en dropped mid-line must not abort the frame.
        applyStimulus(H_DISP, 24'hABCDEF, 24'h13579B, 1'b1);
        waitData("line2");
        tx_en = 1'b0;
        waitDrain("line2_txen_low");
        tx_en = 1'b1;
        checkOutput("line2_line_num", 36'(line_num), 36'h2);
        rec_q.delete();

        pulseVsync();
        applyStimulus(H_DISP, 24'hFF0000, 24'h00FF01, 1'b1);
        waitDrain("line_restart");
        checkOutput("restart_header", recAt(0), {4'b0001, 32'h0000_01FB});
        checkOutput("restart_line_num", 36'(line_num), 36'h0);
        rec_q.delete();

        // Overflow with the link held down, then release it.
        tx_en = 1'b0;
        applyStimulus(H_DISP, 24'h123456, 24'h010101, 1'b1);
        applyStimulus(1, 24'hDEADBE, 24'h000000, 1'b0);
        tick();
        checkOutput("ovf_err_set", 36'(ovf_err), 36'h1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("ovf_tx_idle%0d", i), {tx_charisk, tx_data}, IDLE36);
            tick();
        end
        tx_en = 1'b1;
        waitDrain("ovf_line");
        checkOutput("ovf_header", recAt(0), {4'b0001, 32'h0001_00FB});
        rec_q.delete();

        // Reset in the middle of DATA.
        applyStimulus(H_DISP, 24'h0F0F0F, 24'h102030, 1'b1);
        waitData("rst_mid");
        rst_n = 1'b0;
        exp_q.delete();
        line_buf.delete();
        model_next_line = 0;
        model_restart   = 1'b0;
        #1;
        checkOutput("rst_mid_idle", {tx_charisk, tx_data}, IDLE36);
        checkOutput("rst_mid_ovf_err", 36'(ovf_err), 36'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rec_q.delete();
        pulseVsync();
        applyStimulus(H_DISP, 24'h000001, 24'h000001, 1'b1);
        waitDrain("post_reset");
        checkOutput("post_reset_header", recAt(0), {4'b0001, 32'h0000_01FB});
        checkOutput("post_reset_tail", recAt(7), {4'b0001, 32'h0000_08FD});

        // Partial line followed by vsync.
        pulseVsync();
        checkOutput("len_err_clean_vsync", 36'(len_err), 36'h0);
        applyStimulus(5, 24'h777777, 24'h000001, 1'b1);
        pulseVsync();
        tick();
        checkOutput("len_err_set", 36'(len_err), 36'h1);
        repeat (4) tick();
        checkOutput("partial_tx_idle", {tx_charisk, tx_data}, IDLE36);
        checkOutput("final_queue_empty", 36'(exp_q.size()), 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish sooner", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
